// File: rtl/decode_stage.sv
// decode_stage: ID stage plus the ID/EX pipeline register of the 8-bit,
// 4-register pipelined core. It decodes the IF/ID word and drives the
// register-file read addresses. It detects load-use hazards, stalling
// IF/ID and injecting a bubble. It also picks the operand forwarding sources.
module decode_stage #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         if_instr,
  input  logic               if_valid,
  input  logic               flush,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic               mem_reg_write,
  output logic [RADDR_W-1:0] rf_rd_addr1,
  output logic [RADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0]  rf_rd_data1,
  input  logic [DATA_W-1:0]  rf_rd_data2,
  output logic               stall,
  output logic               idex_valid,
  output logic               idex_reg_write,
  output logic               idex_mem_read,
  output logic               idex_mem_write,
  output logic [2:0]         idex_alu_op,
  output logic [RADDR_W-1:0] idex_rd,
  output logic [DATA_W-1:0]  idex_a,
  output logic [DATA_W-1:0]  idex_b,
  output logic [1:0]         idex_fwd_a,
  output logic [1:0]         idex_fwd_b,
  output logic               illegal
);

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_LOAD  = 4'b0101;
  localparam logic [3:0] OP_STORE = 4'b0110;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXM  = 2'b01;
  localparam logic [1:0] FWD_MWB  = 2'b10;

  logic [3:0]         opcode;
  logic [RADDR_W-1:0] rs1;
  logic [RADDR_W-1:0] rs2;

  logic [2:0] dec_alu_op;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_use_rs1;
  logic       dec_use_rs2;
  logic       dec_illegal;

  logic       hazard;

  logic               valid_q,     valid_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_read_q,  mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [2:0]         alu_op_q,    alu_op_d;
  logic [RADDR_W-1:0] rd_q,        rd_d;
  logic [DATA_W-1:0]  a_q,         a_d;
  logic [DATA_W-1:0]  b_q,         b_d;
  logic [1:0]         fwd_a_q,     fwd_a_d;
  logic [1:0]         fwd_b_q,     fwd_b_d;
  logic               illegal_q,   illegal_d;

  assign opcode = if_instr[7:4];
  assign rs1    = if_instr[2 +: RADDR_W];
  assign rs2    = if_instr[0 +: RADDR_W];

  assign rf_rd_addr1 = rs1;
  assign rf_rd_addr2 = rs2;

  // Forward source for one register index, based on the instructions ahead.
  // A load in ID/EX can't forward from EX/MEM; that case is the interlock.
  function automatic logic [1:0] fwd_sel(input logic [RADDR_W-1:0] src);
    if (valid_q && reg_write_q && !mem_read_q && (rd_q == src))
      return FWD_EXM;
    else if (mem_reg_write && (mem_rd == src))
      return FWD_MWB;
    else
      return FWD_RF;
  endfunction

  // Opcode decode; undefined opcodes behave as NOP but are flagged.
  always_comb begin
    dec_alu_op    = 3'b000;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_use_rs1   = 1'b0;
    dec_use_rs2   = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD: begin
        dec_alu_op = 3'b001; dec_reg_write = 1'b1;
        dec_use_rs1 = 1'b1;  dec_use_rs2 = 1'b1;
      end
      OP_SUB: begin
        dec_alu_op = 3'b010; dec_reg_write = 1'b1;
        dec_use_rs1 = 1'b1;  dec_use_rs2 = 1'b1;
      end
      OP_AND: begin
        dec_alu_op = 3'b011; dec_reg_write = 1'b1;
        dec_use_rs1 = 1'b1;  dec_use_rs2 = 1'b1;
      end
      OP_OR: begin
        dec_alu_op = 3'b100; dec_reg_write = 1'b1;
        dec_use_rs1 = 1'b1;  dec_use_rs2 = 1'b1;
      end
      OP_LOAD: begin
        dec_alu_op = 3'b001; dec_reg_write = 1'b1; dec_mem_read = 1'b1;
        dec_use_rs2 = 1'b1;
      end
      OP_STORE: begin
        dec_alu_op = 3'b001; dec_mem_write = 1'b1;
        dec_use_rs1 = 1'b1;  dec_use_rs2 = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Load-use interlock: a load in ID/EX whose result the live instruction needs.
  always_comb begin
    hazard = if_valid && valid_q && mem_read_q &&
             ((dec_use_rs1 && (rs1 == rd_q)) || (dec_use_rs2 && (rs2 == rd_q)));
  end

  // A flush kills the dependent instruction, so there is nothing to hold.
  assign stall = hazard && !flush && !rst;

  // ID/EX next state: bubble unless a live instruction advances this cycle.
  // A bubble leaves rd and the operands as they were.
  always_comb begin
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_op_d    = 3'b000;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    illegal_d   = 1'b0;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    if (!flush && !hazard && if_valid) begin
      valid_d     = 1'b1;
      reg_write_d = dec_reg_write;
      mem_read_d  = dec_mem_read;
      mem_write_d = dec_mem_write;
      alu_op_d    = dec_alu_op;
      illegal_d   = dec_illegal;
      rd_d        = rs1;
      a_d         = rf_rd_data1;
      b_d         = rf_rd_data2;
      fwd_a_d     = dec_use_rs1 ? fwd_sel(rs1) : FWD_RF;
      fwd_b_d     = dec_use_rs2 ? fwd_sel(rs2) : FWD_RF;
    end
  end

  // ID/EX register with synchronous reset to an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_op_q    <= 3'b000;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      illegal_q   <= illegal_d;
    end
  end

  assign idex_valid     = valid_q;
  assign idex_reg_write = reg_write_q;
  assign idex_mem_read  = mem_read_q;
  assign idex_mem_write = mem_write_q;
  assign idex_alu_op    = alu_op_q;
  assign idex_rd        = rd_q;
  assign idex_a         = a_q;
  assign idex_b         = b_q;
  assign idex_fwd_a     = fwd_a_q;
  assign idex_fwd_b     = fwd_b_q;
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by a randomized
// instruction stream, all checked against a behavioural ID/EX model.
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] if_instr;
  logic       if_valid;
  logic       flush;
  logic [1:0] mem_rd;
  logic       mem_reg_write;
  logic [1:0] rf_rd_addr1, rf_rd_addr2;
  logic [7:0] rf_rd_data1, rf_rd_data2;
  logic       stall;
  logic       idex_valid, idex_reg_write, idex_mem_read, idex_mem_write;
  logic [2:0] idex_alu_op;
  logic [1:0] idex_rd;
  logic [7:0] idex_a, idex_b;
  logic [1:0] idex_fwd_a, idex_fwd_b;
  logic       illegal;

  logic [7:0] rf [4];
  assign rf_rd_data1 = rf[rf_rd_addr1];
  assign rf_rd_data2 = rf[rf_rd_addr2];

  decode_stage #(.DATA_W(8), .RADDR_W(2)) dut (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_valid(if_valid),
    .flush(flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .stall(stall), .idex_valid(idex_valid), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
    .idex_alu_op(idex_alu_op), .idex_rd(idex_rd), .idex_a(idex_a),
    .idex_b(idex_b), .idex_fwd_a(idex_fwd_a), .idex_fwd_b(idex_fwd_b),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid, rw, mr, mw;
    logic [2:0] alu;
    logic [1:0] rd;
    logic [7:0] a, b;
    logic [1:0] fa, fb;
    logic       ill;
  } idex_t;

  idex_t m = '0;
  int    n_checks = 0;
  int    n_pass = 0;
  logic  obs_stall;
  logic  exp_stall_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Decode table: {alu_op, reg_write, mem_read, mem_write, uses_rs1, uses_rs2, illegal}
  function automatic logic [8:0] spec_decode(input logic [3:0] op);
    case (op)
      4'h0: return {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      4'h1: return {3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      4'h2: return {3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      4'h3: return {3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      4'h4: return {3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      4'h5: return {3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      4'h6: return {3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      default: return {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    endcase
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [1:0] s);
    if (m.valid && m.rw && !m.mr && m.rd == s) return 2'b01;
    if (mem_reg_write && mem_rd == s) return 2'b10;
    return 2'b00;
  endfunction

  // One clock: check combinational outputs, predict ID/EX, compare after the edge.
  task automatic step();
    idex_t      nx;
    logic [8:0] d;
    logic [1:0] s1, s2;
    logic       u1, u2, hz, es;
    #1;
    s1 = if_instr[3:2];
    s2 = if_instr[1:0];
    d  = spec_decode(if_instr[7:4]);
    u1 = d[2];
    u2 = d[1];
    hz = if_valid && m.valid && m.mr && ((u1 && s1 == m.rd) || (u2 && s2 == m.rd));
    es = hz && !flush && !rst;
    obs_stall = stall;
    chk("stall", {31'd0, stall}, {31'd0, es});
    chk("rf_rd_addr1", {30'd0, rf_rd_addr1}, {30'd0, s1});
    chk("rf_rd_addr2", {30'd0, rf_rd_addr2}, {30'd0, s2});
    nx = m;
    nx.valid = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0;
    nx.alu = 3'd0; nx.fa = 2'd0; nx.fb = 2'd0; nx.ill = 1'b0;
    if (rst) begin
      nx = '0;
    end else if (!flush && !hz && if_valid) begin
      nx.valid = 1'b1;
      nx.alu = d[8:6]; nx.rw = d[5]; nx.mr = d[4]; nx.mw = d[3]; nx.ill = d[0];
      nx.rd = s1;
      nx.a  = rf[s1];
      nx.b  = rf[s2];
      nx.fa = u1 ? exp_fwd(s1) : 2'b00;
      nx.fb = u2 ? exp_fwd(s2) : 2'b00;
    end
    exp_stall_q = es;
    @(posedge clk);
    #1;
    m = nx;
    chk("idex_ctrl",
        {20'd0, idex_valid, idex_reg_write, idex_mem_read, idex_mem_write,
         idex_alu_op, idex_fwd_a, idex_fwd_b, illegal},
        {20'd0, m.valid, m.rw, m.mr, m.mw, m.alu, m.fa, m.fb, m.ill});
    chk("idex_rd", {30'd0, idex_rd}, {30'd0, m.rd});
    chk("idex_a", {24'd0, idex_a}, {24'd0, m.a});
    chk("idex_b", {24'd0, idex_b}, {24'd0, m.b});
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] ins,
                       input logic f, input logic [1:0] mrd, input logic mrw);
    @(negedge clk);
    rst = r; if_valid = v; if_instr = ins; flush = f;
    mem_rd = mrd; mem_reg_write = mrw;
    step();
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b1; if_instr = 8'h16; flush = 1'b0;
    mem_rd = 2'd0; mem_reg_write = 1'b0;
    for (int i = 0; i < 4; i++) rf[i] = 8'(i);

    // Reset held two cycles with a live ADD.
    drive(1, 1, 8'h16, 0, 0, 0);
    drive(1, 1, 8'h16, 0, 0, 0);
    chk("rst_stall", {31'd0, obs_stall}, 32'd0);
    chk("rst_valid", {31'd0, idex_valid}, 32'd0);
    chk("rst_a", {24'd0, idex_a}, 32'd0);

    // Independent ADD R1,R2 then OR R3,R0.
    drive(0, 1, 8'h16, 0, 0, 0);
    chk("add_a", {24'd0, idex_a}, 32'd1);
    chk("add_b", {24'd0, idex_b}, 32'd2);
    chk("add_alu", {29'd0, idex_alu_op}, 32'd1);
    chk("add_fwd", {28'd0, idex_fwd_a, idex_fwd_b}, 32'd0);
    drive(0, 1, 8'h4C, 0, 0, 0);
    chk("or_alu", {29'd0, idex_alu_op}, 32'd4);
    chk("or_fwd", {28'd0, idex_fwd_a, idex_fwd_b}, 32'd0);

    // ADD R1,R2 then SUB R0,R1: EX/MEM forward on source b.
    drive(0, 1, 8'h16, 0, 0, 0);
    drive(0, 1, 8'h21, 0, 0, 0);
    chk("sub_fwd_exm", {28'd0, idex_fwd_a, idex_fwd_b}, 32'b0001);
    drive(0, 0, 8'h00, 0, 0, 0);
    drive(0, 1, 8'h21, 0, 2'd1, 1);
    chk("sub_fwd_mwb", {28'd0, idex_fwd_a, idex_fwd_b}, 32'b0010);

    // LOAD R2,[R0] then ADD R1,R2: one bubble, then forward from MEM/WB.
    drive(0, 1, 8'h58, 0, 0, 0);
    drive(0, 1, 8'h16, 0, 0, 0);
    chk("lu_stall", {31'd0, obs_stall}, 32'd1);
    chk("lu_bubble", {31'd0, idex_valid}, 32'd0);
    drive(0, 1, 8'h16, 0, 2'd2, 1);
    chk("lu_nostall", {31'd0, obs_stall}, 32'd0);
    chk("lu_valid", {31'd0, idex_valid}, 32'd1);
    chk("lu_fwd_b", {30'd0, idex_fwd_b}, 32'd2);

    // Load-use together with flush, then flush alone.
    drive(0, 1, 8'h58, 0, 0, 0);
    drive(0, 1, 8'h16, 1, 0, 0);
    chk("flush_stall", {31'd0, obs_stall}, 32'd0);
    chk("flush_bubble", {31'd0, idex_valid}, 32'd0);
    drive(0, 1, 8'h16, 1, 0, 0);
    chk("flush_only", {31'd0, idex_valid}, 32'd0);

    // Undefined opcode, then a not-live slot.
    drive(0, 1, 8'hF3, 0, 0, 0);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_ctrl", {29'd0, idex_valid, idex_reg_write, idex_mem_write}, 32'b100);
    drive(0, 0, 8'h16, 0, 0, 0);
    chk("inv_bubble", {30'd0, idex_valid, illegal}, 32'd0);

    // Reset arriving during a load-use stall.
    drive(0, 1, 8'h58, 0, 0, 0);
    drive(1, 1, 8'h16, 0, 0, 0);
    chk("rst_mid_stall", {31'd0, obs_stall}, 32'd0);
    chk("rst_mid_valid", {31'd0, idex_valid}, 32'd0);

    // Randomized stream; IF/ID holds whenever the model expects a stall.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 7) == 0);
      mem_rd = 2'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) rf[$urandom_range(0, 3)] = 8'($urandom);
      if (!exp_stall_q) begin
        if_valid = ($urandom_range(0, 5) != 0);
        if ($urandom_range(0, 3) == 0)
          if_instr = {4'h5, 4'($urandom)};
        else
          if_instr = 8'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage and ID/EX pipeline register of the 8-bit, 4-register pipelined RISC core.
- Decodes the instruction word held in IF/ID and drives the register-file read addresses combinationally.
- Each cycle, registers the operands, control bits and forwarding selects into ID/EX for the EX stage.
- Owns the load-use interlock: it stalls IF/ID and injects bubbles.
- Also handles branch flush from EX.

Parameters:
- DATA_W, 8, register/operand width.
- RADDR_W, 2, register index width (4 registers).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- if_instr  in  8  IF/ID instruction: [7:4] opcode, [3:2] rd/rs1, [1:0] rs2.
- if_valid  in  1  IF/ID holds a real instruction.
- flush  in  1  branch taken in EX; kill the instruction in ID.
- mem_rd  in  RADDR_W  destination register of the instruction in EX/MEM.
- mem_reg_write  in  1  EX/MEM instruction writes the register file.
- rf_rd_addr1  out  RADDR_W  register-file read address 1; equals if_instr[3:2].
- rf_rd_addr2  out  RADDR_W  register-file read address 2; equals if_instr[1:0].
- rf_rd_data1  in  DATA_W  register-file read data 1.
- rf_rd_data2  in  DATA_W  register-file read data 2.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- idex_valid, idex_reg_write, idex_mem_read, idex_mem_write  out  1 each  ID/EX control bits.
- idex_alu_op  out  3  ALU operation.
- idex_rd  out  RADDR_W  destination register.
- idex_a, idex_b  out  DATA_W  operand values.
- idex_fwd_a, idex_fwd_b  out  2  operand source: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- illegal  out  1  registered; the ID/EX instruction had an undefined opcode.

Behaviour:
- Decode table (opcode -> alu_op, reg_write, mem_read, mem_write, uses rs1, uses rs2):
  - 0000 NOP -> 000, 0, 0, 0, no, no
  - 0001 ADD -> 001, 1, 0, 0, yes, yes
  - 0010 SUB -> 010, 1, 0, 0, yes, yes
  - 0011 AND -> 011, 1, 0, 0, yes, yes
  - 0100 OR -> 100, 1, 0, 0, yes, yes
  - 0101 LOAD (rd <- mem[rs2]) -> 001, 1, 1, 0, no, yes
  - 0110 STORE (mem[rs2] <- rd) -> 001, 0, 0, 1, yes, yes
  - All other opcodes: decode as NOP with illegal=1.
- rd is always if_instr[3:2]; rs1 = [3:2]; rs2 = [1:0].
- Decoded instruction is "live" when if_valid=1.
- Bubble: idex_valid=0, all control bits 0, alu_op 000, fwd 00, illegal 0. idex_rd, idex_a and idex_b hold their previous values (don't-care).
- Reset: every output register cleared to 0, i.e. a bubble.
- stall is forced to 0 while rst=1.
- Load-use hazard (combinational), all of the following true:
  - idex_valid=1 and idex_mem_read=1;
  - the live instruction uses rs1 with rs1==idex_rd, or uses rs2 with rs2==idex_rd.
- stall = hazard and not flush.
- Posedge priority:
  1. rst -> bubble.
  2. flush -> bubble.
  3. hazard -> bubble; IF/ID holds via stall, so the same instruction is re-decoded next cycle.
  4. otherwise -> load the decoded instruction; a not-live instruction loads as a bubble.
- Forward select for each used source s, computed at decode time:
  - 01 if idex_valid=1, idex_reg_write=1, idex_mem_read=0 and idex_rd==s. The instruction ahead will sit in EX/MEM.
  - else 10 if mem_reg_write=1 and mem_rd==s. That instruction will sit in MEM/WB.
  - else 00.
  - An unused source always gets 00.
- Register-file write visibility: writes land on negedge, so a WB write in the same cycle is already visible in rf_rd_data. No WB bypass is needed here.
- Latency: 1 cycle from IF/ID to ID/EX. Each load-use stall costs exactly 1 bubble; after it, the dependent source gets fwd=10.
- Reset asserted mid-stall: bubble on the next edge; stall drops while rst=1.

Test Plan:
- Reset: rst=1 for 2 cycles with if_valid=1 and ADD -> all idex_* = 0 and stall = 0. First ADD appears the cycle after rst falls.
- Independent stream ADD R1,R2 (0x16) then OR R3,R0 (0x4C), with rf R0..R3 = 0,1,2,3:
  - ADD -> idex_a=1, idex_b=2, alu_op 001, fwd 00/00;
  - next cycle OR -> alu_op 100, fwd 00/00.
- ADD R1,R2 followed by SUB R0,R1 (0x21) -> SUB latches fwd_a=00, fwd_b=01. With mem_rd=1 and mem_reg_write=1 instead (and no ID/EX match) -> fwd_b=10.
- LOAD R2,[R0] (0x58) followed by ADD R1,R2 (0x16):
  - stall=1 for one cycle, ID/EX gets a bubble;
  - next edge ADD latches with fwd_b=10, idex_valid=1.
- Load-use hazard with flush=1 in the same cycle -> stall=0, ID/EX bubble. Flush alone -> bubble irrespective of if_valid.
- Opcode 0xF3 -> illegal=1, idex_valid=1, reg_write=0, mem_write=0. if_valid=0 -> bubble, illegal=0.
